fetch_redirect_stage: RTL and testbench
=======================================

# fetch_redirect_stage

Instruction-fetch stage and IF/ID pipeline buffer for the Project4 pipelined processor. It owns the PC, drives the instruction-memory address, registers the fetched instruction with its PC+4, and consumes the redirect protocol produced at the EX/MEM boundary (`pcMux`, `branchTarget`, `jal`, then a one-cycle `flushIn`). It squashes the wrong-path instruction on a redirect and keeps redirect statistics and a protocol-error flag for debug.

## Interface
- `BIT_WIDTH`, 32, datapath / PC / instruction width
- `RESET_PC`, 0, PC value loaded on reset
- `CNT_WIDTH`, 16, width of the statistics counters
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `stall`  in  1  hazard-unit hold; freezes PC and IF/ID register
- `pcMux`  in  1  redirect request, high for one cycle
- `jal`  in  1  qualifies `pcMux` as jump-and-link (counted only)
- `branchTarget`  in  BIT_WIDTH  redirect target PC, valid when `pcMux`=1
- `flushIn`  in  1  flush pulse, expected exactly one cycle after a `pcMux` pulse
- `imemAddr`  out  BIT_WIDTH  instruction-memory address; equals current PC register
- `imemData`  in  BIT_WIDTH  instruction word, combinational read of `imemAddr`
- `instOut`  out  BIT_WIDTH  IF/ID instruction; 0 (NOP) when not valid
- `pcOut`  out  BIT_WIDTH  IF/ID PC+4 of `instOut`
- `validOut`  out  1  IF/ID contents are a correct-path instruction
- `redirectCount`  out  CNT_WIDTH  accepted redirects, saturating
- `jalCount`  out  CNT_WIDTH  accepted redirects with `jal`=1, saturating
- `protoErr`  out  1  sticky: `flushIn` missing in the cycle after an accepted redirect

## Operation
- States: BOOT, RUN, REDIR. Reset enters BOOT.
- Accepted redirect = `pcMux` && !`flushIn` && state != BOOT. `pcMux` while `flushIn`=1 is ignored.
- Per rising edge, in priority order:
  - `rst`: PC<=RESET_PC; `instOut`,`pcOut`<=0; `validOut`<=0; counters<=0; `protoErr`<=0; state<=BOOT.
  - BOOT: PC held, IF/ID held invalid; state<=RUN (no fetch, regardless of `stall`/`pcMux`).
  - Accepted redirect (overrides `stall`): PC<=`branchTarget`; `instOut`<=0; `validOut`<=0; `pcOut`<=0; `redirectCount`++, `jalCount`++ if `jal`; state<=REDIR.
  - `stall`=1: PC, `instOut`, `pcOut`, `validOut` held.
  - Otherwise fetch: `instOut`<=`imemData`; `pcOut`<=PC+4; `validOut`<=1; PC<=PC+4.
- REDIR: fetch rules above apply normally (target path is correct path); if `flushIn`=0 this cycle, `protoErr`<=1; state<=RUN unless a new accepted redirect occurs (then stays REDIR).
- RUN: state changes only on accepted redirect.
- PC arithmetic modulo 2^BIT_WIDTH; 0xFFFFFFFC+4 wraps to 0. `branchTarget` loaded unmodified (no alignment forcing).
- Counters saturate at all-ones; never wrap.
- `protoErr` clears only on `rst`.

## Timing
- `imemAddr` is the PC register output; no combinational path from any input to any output.
- Fetch latency: instruction at PC P appears on `instOut` with `pcOut`=P+4 one edge after P is on `imemAddr` (absent stall/redirect).
- Reset: after `rst` deasserts, first edge is BOOT (no fetch); second edge captures instruction at RESET_PC.
- Redirect: `pcMux` sampled at edge N -> `imemAddr`=`branchTarget` and `validOut`=0 after N; target instruction valid after edge N+1 (one bubble).
- `stall` held k cycles -> outputs frozen k cycles, then resume from the same PC.
- `rst` in REDIR or under stall behaves exactly as reset from RUN.

## Test plan
- Reset/boot: RESET_PC=0, imem[0]=0xA, imem[4]=0xB, no stall -> edge1 after reset `validOut`=0, `imemAddr`=0; edge2 `instOut`=0xA, `pcOut`=4, `imemAddr`=4; edge3 `instOut`=0xB, `pcOut`=8.
- Stall: `stall`=1 for 3 cycles at `imemAddr`=8 -> `instOut`/`pcOut`/`imemAddr` unchanged for 3 cycles, then `instOut`=imem[8], `pcOut`=12.
- Redirect: `pcMux`=1, `branchTarget`=0x100, `jal`=1, then `flushIn`=1 next cycle -> `imemAddr`=0x100, `validOut`=0, `redirectCount`=1, `jalCount`=1; next edge `instOut`=imem[0x100], `pcOut`=0x104, `protoErr`=0.
- Redirect under stall, ignored pcMux: `pcMux`=1 with `stall`=1 -> PC=target; `pcMux`=1 with `flushIn`=1 -> no redirect, `redirectCount` unchanged.
- Protocol error and wrap: accepted redirect to 0xFFFFFFFC followed by `flushIn`=0 -> `protoErr`=1 sticky; following fetches give `pcOut`=0, `imemAddr`=0.
- Reset mid-REDIR: `rst` in cycle after `pcMux` -> all outputs 0, `imemAddr`=RESET_PC, counters 0, `protoErr`=0, BOOT bubble repeats.

Source files
------------

// File: rtl/fetch_redirect_stage_if.sv
// Fetch stage bus: hazard/redirect controls, imem port and IF/ID outputs.
// master drives controls and imem data; slave is the fetch stage.
interface fetch_redirect_stage_if #(
  parameter int BIT_WIDTH = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 stall;
  logic                 pcMux;
  logic                 jal;
  logic [BIT_WIDTH-1:0] branchTarget;
  logic                 flushIn;
  logic [BIT_WIDTH-1:0] imemAddr;
  logic [BIT_WIDTH-1:0] imemData;
  logic [BIT_WIDTH-1:0] instOut;
  logic [BIT_WIDTH-1:0] pcOut;
  logic                 validOut;
  logic [CNT_WIDTH-1:0] redirectCount;
  logic [CNT_WIDTH-1:0] jalCount;
  logic                 protoErr;

  modport master (
    output stall, pcMux, jal, branchTarget, flushIn, imemData,
    input  imemAddr, instOut, pcOut, validOut,
    input  redirectCount, jalCount, protoErr
  );

  modport slave (
    input  stall, pcMux, jal, branchTarget, flushIn, imemData,
    output imemAddr, instOut, pcOut, validOut,
    output redirectCount, jalCount, protoErr
  );
endinterface

// File: rtl/fetch_redirect_stage.sv
// Instruction fetch with IF/ID buffer; applies EX/MEM redirects,
// squashes the wrong-path slot and tracks redirect statistics.
module fetch_redirect_stage #(
  parameter int                BIT_WIDTH = 32,
  parameter logic [BIT_WIDTH-1:0] RESET_PC = '0,
  parameter int                CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_redirect_stage_if.slave bus
);
  typedef enum logic [1:0] {
    BOOT,
    RUN,
    REDIR
  } state_t;

  state_t               r_state;
  logic [BIT_WIDTH-1:0] r_pc;
  logic [BIT_WIDTH-1:0] r_inst;
  logic [BIT_WIDTH-1:0] r_pc4;
  logic                 r_valid;
  logic [CNT_WIDTH-1:0] r_redir_cnt;
  logic [CNT_WIDTH-1:0] r_jal_cnt;
  logic                 r_proto_err;

  logic                 w_accept;
  logic [BIT_WIDTH-1:0] w_pc_next;

  // A redirect coinciding with its own flush slot is ignored.
  assign w_accept  = bus.pcMux && !bus.flushIn
                     && (r_state != BOOT);
  assign w_pc_next = r_pc + BIT_WIDTH'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= BOOT;
      r_pc        <= RESET_PC;
      r_inst      <= '0;
      r_pc4       <= '0;
      r_valid     <= 1'b0;
      r_redir_cnt <= '0;
      r_jal_cnt   <= '0;
      r_proto_err <= 1'b0;
    end else if (r_state == BOOT) begin
      r_state <= RUN;
    end else begin
      if (r_state == REDIR && !bus.flushIn)
        r_proto_err <= 1'b1;
      if (w_accept) begin
        r_pc    <= bus.branchTarget;
        r_inst  <= '0;
        r_pc4   <= '0;
        r_valid <= 1'b0;
        r_state <= REDIR;
        if (r_redir_cnt != '1)
          r_redir_cnt <= r_redir_cnt + 1'b1;
        if (bus.jal && r_jal_cnt != '1)
          r_jal_cnt <= r_jal_cnt + 1'b1;
      end else begin
        r_state <= RUN;
        if (!bus.stall) begin
          r_inst  <= bus.imemData;
          r_pc4   <= w_pc_next;
          r_valid <= 1'b1;
          r_pc    <= w_pc_next;
        end
      end
    end
  end

  assign bus.imemAddr      = r_pc;
  assign bus.instOut       = r_inst;
  assign bus.pcOut         = r_pc4;
  assign bus.validOut      = r_valid;
  assign bus.redirectCount = r_redir_cnt;
  assign bus.jalCount      = r_jal_cnt;
  assign bus.protoErr      = r_proto_err;
endmodule

// File: tb/tb_fetch_redirect_stage.sv
// Directed bench for fetch_redirect_stage: boot, stall, redirect,
// ignored redirect, protocol error with PC wrap, reset mid-redirect.
module tb_fetch_redirect_stage;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fetch_redirect_stage_if #(.BIT_WIDTH(32), .CNT_WIDTH(16)) bus ();

  fetch_redirect_stage #(
    .BIT_WIDTH(32),
    .RESET_PC (32'h0),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // imem[0]=0xA, imem[4]=0xB, elsewhere {0xA5, addr[23:0]}
  always_comb begin
    bus.imemData = {8'hA5, bus.imemAddr[23:0]};
    if (bus.imemAddr == 32'h0) bus.imemData = 32'hA;
    if (bus.imemAddr == 32'h4) bus.imemData = 32'hB;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string tag,
                        input logic [31:0] inst,
                        input logic [31:0] pc4,
                        input logic        vld,
                        input logic [31:0] addr);
    chk({tag, ".inst"}, bus.instOut, inst);
    chk({tag, ".pc4"}, bus.pcOut, pc4);
    chk({tag, ".vld"}, 32'(bus.validOut), 32'(vld));
    chk({tag, ".addr"}, bus.imemAddr, addr);
  endtask

  task automatic chk_stat(input string tag,
                          input int rc,
                          input int jc,
                          input logic pe);
    chk({tag, ".rcnt"}, 32'(bus.redirectCount), 32'(rc));
    chk({tag, ".jcnt"}, 32'(bus.jalCount), 32'(jc));
    chk({tag, ".perr"}, 32'(bus.protoErr), 32'(pe));
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.pcMux = 1'b0;
    bus.jal = 1'b0;
    bus.flushIn = 1'b0;
    bus.branchTarget = '0;
    tick();
    tick();
    chk_if("rst", 32'h0, 32'h0, 1'b0, 32'h0);
    chk_stat("rst", 0, 0, 1'b0);

    rst = 1'b0;
    tick();
    chk_if("boot", 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    chk_if("f0", 32'hA, 32'h4, 1'b1, 32'h4);
    tick();
    chk_if("f1", 32'hB, 32'h8, 1'b1, 32'h8);

    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_if("stall", 32'hB, 32'h8, 1'b1, 32'h8);
    end
    bus.stall = 1'b0;
    tick();
    chk_if("unstall", 32'hA500_0008, 32'hC, 1'b1, 32'hC);

    bus.pcMux = 1'b1;
    bus.jal = 1'b1;
    bus.branchTarget = 32'h100;
    tick();
    chk_if("redir", 32'h0, 32'h0, 1'b0, 32'h100);
    chk_stat("redir", 1, 1, 1'b0);
    bus.pcMux = 1'b0;
    bus.jal = 1'b0;
    bus.flushIn = 1'b1;
    tick();
    chk_if("tgt", 32'hA500_0100, 32'h104, 1'b1, 32'h104);
    chk_stat("tgt", 1, 1, 1'b0);
    bus.flushIn = 1'b0;

    bus.stall = 1'b1;
    bus.pcMux = 1'b1;
    bus.branchTarget = 32'h200;
    tick();
    chk_if("rstall", 32'h0, 32'h0, 1'b0, 32'h200);
    chk_stat("rstall", 2, 1, 1'b0);
    bus.pcMux = 1'b0;
    bus.flushIn = 1'b1;
    tick();
    chk_if("rstall2", 32'h0, 32'h0, 1'b0, 32'h200);
    chk_stat("rstall2", 2, 1, 1'b0);

    bus.stall = 1'b0;
    bus.pcMux = 1'b1;
    bus.branchTarget = 32'h300;
    tick();
    chk_if("ignored", 32'hA500_0200, 32'h204, 1'b1, 32'h204);
    chk_stat("ignored", 2, 1, 1'b0);

    bus.flushIn = 1'b0;
    bus.branchTarget = 32'hFFFF_FFFC;
    tick();
    chk_if("wrapr", 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFC);
    chk_stat("wrapr", 3, 1, 1'b0);
    bus.pcMux = 1'b0;
    tick();
    chk_if("wrap", 32'hA5FF_FFFC, 32'h0, 1'b1, 32'h0);
    chk_stat("perr", 3, 1, 1'b1);
    tick();
    chk_if("wrap2", 32'hA, 32'h4, 1'b1, 32'h4);
    chk_stat("sticky", 3, 1, 1'b1);

    bus.pcMux = 1'b1;
    bus.branchTarget = 32'h40;
    tick();
    chk_if("mid", 32'h0, 32'h0, 1'b0, 32'h40);
    bus.pcMux = 1'b0;
    rst = 1'b1;
    tick();
    chk_if("rst2", 32'h0, 32'h0, 1'b0, 32'h0);
    chk_stat("rst2", 0, 0, 1'b0);
    rst = 1'b0;
    tick();
    chk_if("boot2", 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    chk_if("f0b", 32'hA, 32'h4, 1'b1, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
